// File: rtl/branch_cond_unit.sv
// Branch condition unit: evaluates a MIPS-style branch condition and next-PC,
// holds the result in a single ready/valid output register, and keeps
// saturating counts of transferred results.
module branch_cond_unit #(
  parameter int WIDTH = 32,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [PC_W-1:0]  pc,
  input  logic [15:0]      imm,
  output logic             valid_out,
  input  logic             ready_out,
  output logic             taken,
  output logic [PC_W-1:0]  target,
  output logic             bad_op,
  output logic             flush,
  input  logic             clear,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] total_cnt
);

  localparam logic [PC_W-1:0]  PC_FOUR = PC_W'(4);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             valid_out_q, valid_out_d;
  logic             taken_q, taken_d;
  logic [PC_W-1:0]  target_q, target_d;
  logic             bad_op_q, bad_op_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] total_cnt_q, total_cnt_d;

  logic             in_xfer;
  logic             out_xfer;
  logic             rs_neg;
  logic             rs_zero;
  logic             cond;
  logic             reserved;
  logic [PC_W-1:0]  imm_ext;
  logic [PC_W-1:0]  pc_plus4;

  assign ready_in = !valid_out_q || ready_out;
  assign in_xfer  = valid_in && ready_in;
  assign out_xfer = valid_out_q && ready_out;
  assign flush    = out_xfer && taken_q;

  // Signed tests against zero reduce to the sign bit and a zero detect.
  assign rs_neg   = rs[WIDTH-1];
  assign rs_zero  = (rs == '0);
  assign reserved = op[2] && op[1];
  assign imm_ext  = {{(PC_W-16){imm[15]}}, imm};
  assign pc_plus4 = pc + PC_FOUR;

  always_comb begin
    cond = 1'b0;
    case (op)
      3'd0:    cond = (rs == rt);
      3'd1:    cond = (rs != rt);
      3'd2:    cond = rs_neg || rs_zero;
      3'd3:    cond = !rs_neg && !rs_zero;
      3'd4:    cond = rs_neg;
      3'd5:    cond = !rs_neg;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    valid_out_d = valid_out_q;
    taken_d     = taken_q;
    target_d    = target_q;
    bad_op_d    = bad_op_q;
    if (in_xfer) begin
      valid_out_d = 1'b1;
      taken_d     = cond;
      bad_op_d    = reserved;
      target_d    = cond ? (pc_plus4 + (imm_ext << 2)) : pc_plus4;
    end else if (out_xfer) begin
      valid_out_d = 1'b0;
    end
  end

  // Clear wins over a coincident increment; both counters stick at all-ones.
  always_comb begin
    taken_cnt_d = taken_cnt_q;
    total_cnt_d = total_cnt_q;
    if (clear) begin
      taken_cnt_d = '0;
      total_cnt_d = '0;
    end else if (out_xfer) begin
      if (!(&total_cnt_q))
        total_cnt_d = total_cnt_q + CNT_ONE;
      if (taken_q && !(&taken_cnt_q))
        taken_cnt_d = taken_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_out_q <= 1'b0;
      taken_q     <= 1'b0;
      target_q    <= '0;
      bad_op_q    <= 1'b0;
      taken_cnt_q <= '0;
      total_cnt_q <= '0;
    end else begin
      valid_out_q <= valid_out_d;
      taken_q     <= taken_d;
      target_q    <= target_d;
      bad_op_q    <= bad_op_d;
      taken_cnt_q <= taken_cnt_d;
      total_cnt_q <= total_cnt_d;
    end
  end

  assign valid_out = valid_out_q;
  assign taken     = taken_q;
  assign target    = target_q;
  assign bad_op    = bad_op_q;
  assign taken_cnt = taken_cnt_q;
  assign total_cnt = total_cnt_q;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed bench for branch_cond_unit with 4-bit counters so saturation is
// reachable; expected values below are worked out by hand from the ISA rules.
module tb_branch_cond_unit;

  localparam int W  = 32;
  localparam int PW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          valid_in = 1'b0;
  logic          ready_out = 1'b0;
  logic          clear = 1'b0;
  logic [2:0]    op = '0;
  logic [W-1:0]  rs = '0;
  logic [W-1:0]  rt = '0;
  logic [PW-1:0] pc = '0;
  logic [15:0]   imm = '0;

  logic          ready_in;
  logic          valid_out;
  logic          taken;
  logic [PW-1:0] target;
  logic          bad_op;
  logic          flush;
  logic [CW-1:0] taken_cnt;
  logic [CW-1:0] total_cnt;

  int checks = 0;
  int errors = 0;

  branch_cond_unit #(.WIDTH(W), .PC_W(PW), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .op        (op),
    .rs        (rs),
    .rt        (rt),
    .pc        (pc),
    .imm       (imm),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .taken     (taken),
    .target    (target),
    .bad_op    (bad_op),
    .flush     (flush),
    .clear     (clear),
    .taken_cnt (taken_cnt),
    .total_cnt (total_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] p, input logic [15:0] i);
    op = o; rs = a; rt = b; pc = p; imm = i; valid_in = 1'b1;
  endtask

  task automatic res(input string tag, input logic t, input logic [31:0] tg, input logic bo);
    chk({tag, ".valid"},  32'(valid_out), 32'd1);
    chk({tag, ".taken"},  32'(taken),     32'(t));
    chk({tag, ".target"}, target,         tg);
    chk({tag, ".bad_op"}, 32'(bad_op),    32'(bo));
  endtask

  task automatic cnts(input string tag, input int tk, input int tot);
    chk({tag, ".taken_cnt"}, 32'(taken_cnt), 32'(tk));
    chk({tag, ".total_cnt"}, 32'(total_cnt), 32'(tot));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2 reset = 1'b0;
    #1;
    chk("rst.valid_out", 32'(valid_out), 32'd0);
    chk("rst.taken",     32'(taken),     32'd0);
    chk("rst.target",    target,         32'd0);
    chk("rst.bad_op",    32'(bad_op),    32'd0);
    chk("rst.ready_in",  32'(ready_in),  32'd1);
    chk("rst.flush",     32'(flush),     32'd0);
    cnts("rst", 0, 0);
    cyc();
    cyc();
    @(negedge clk);
    reset = 1'b1;

    // BEQ taken on the first edge after reset release
    ready_out = 1'b1;
    req(3'd0, 32'h5, 32'h5, 32'h0040_0000, 16'h0003);
    #1 chk("beq.ready_in", 32'(ready_in), 32'd1);
    cyc();
    valid_in = 1'b0;
    res("beq", 1'b1, 32'h0040_0010, 1'b0);
    chk("beq.flush", 32'(flush), 32'd1);
    cyc();
    cnts("beq", 1, 1);
    chk("beq.drain", 32'(valid_out), 32'd0);

    // BLEZ then BGTZ back to back on the most negative operand
    req(3'd2, 32'h8000_0000, 32'h0, 32'h0040_0100, 16'hFFFF);
    cyc();
    res("blez", 1'b1, 32'h0040_0100, 1'b0);
    req(3'd3, 32'h8000_0000, 32'h0, 32'h0040_0100, 16'hFFFF);
    cyc();
    valid_in = 1'b0;
    res("bgtz", 1'b0, 32'h0040_0104, 1'b0);
    chk("bgtz.flush", 32'(flush), 32'd0);
    cyc();
    cnts("bgtz", 2, 3);

    // Backpressure with valid_in held high
    ready_out = 1'b0;
    req(3'd1, 32'h1, 32'h2, 32'h0000_1000, 16'h0001);
    cyc();
    req(3'd1, 32'h3, 32'h3, 32'h0000_2000, 16'h0010);
    for (int i = 0; i < 3; i++) begin
      res($sformatf("bp%0d", i), 1'b1, 32'h0000_1008, 1'b0);
      chk($sformatf("bp%0d.ready_in", i), 32'(ready_in), 32'd0);
      cyc();
    end
    ready_out = 1'b1;
    #1;
    chk("bp.ready_in", 32'(ready_in), 32'd1);
    chk("bp.flush",    32'(flush),    32'd1);
    cyc();
    res("bp_r2", 1'b0, 32'h0000_2004, 1'b0);
    req(3'd4, 32'hFFFF_FFFF, 32'h0, 32'h0000_3000, 16'h0000);
    cyc();
    valid_in = 1'b0;
    res("bp_r3", 1'b1, 32'h0000_3004, 1'b0);
    cyc();
    chk("bp.drain", 32'(valid_out), 32'd0);
    cnts("bp", 4, 6);

    // Reserved ops and PC wrap-around
    req(3'd7, 32'h0, 32'h0, 32'hFFFF_FFFC, 16'h0005);
    cyc();
    res("op7", 1'b0, 32'h0000_0000, 1'b1);
    chk("op7.flush", 32'(flush), 32'd0);
    req(3'd6, 32'h0, 32'h0, 32'h0000_0200, 16'h0001);
    cyc();
    res("op6", 1'b0, 32'h0000_0204, 1'b1);
    req(3'd5, 32'h0, 32'h0, 32'hFFFF_FFF0, 16'h0004);
    cyc();
    valid_in = 1'b0;
    res("bgez", 1'b1, 32'h0000_0004, 1'b0);
    cyc();
    cnts("wrap", 5, 9);

    // Saturation after 20 more taken transfers
    req(3'd0, 32'h0, 32'h0, 32'h0000_0100, 16'h0000);
    repeat (20) cyc();
    valid_in = 1'b0;
    cyc();
    cnts("sat", 15, 15);

    // Clear coinciding with a transfer
    req(3'd0, 32'h0, 32'h0, 32'h0000_0100, 16'h0000);
    cyc();
    valid_in = 1'b0;
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    cnts("clr", 0, 0);

    // Reset mid-cycle with a stalled result pending
    req(3'd1, 32'h1, 32'h2, 32'h0000_0040, 16'h0000);
    cyc();
    valid_in = 1'b0;
    cyc();
    cnts("pre_rst", 1, 1);
    ready_out = 1'b0;
    req(3'd0, 32'h7, 32'h7, 32'h0000_0080, 16'h0002);
    cyc();
    valid_in = 1'b0;
    chk("pend.valid_out", 32'(valid_out), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst.valid_out", 32'(valid_out), 32'd0);
    chk("arst.taken",     32'(taken),     32'd0);
    chk("arst.target",    target,         32'd0);
    chk("arst.ready_in",  32'(ready_in),  32'd1);
    cnts("arst", 0, 0);
    ready_out = 1'b1;
    #1 chk("arst.flush", 32'(flush), 32'd0);
    cyc();
    chk("arst.hold", 32'(valid_out), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    cyc();
    chk("post.valid_out", 32'(valid_out), 32'd0);
    cnts("post", 0, 0);
    cyc();
    chk("post2.valid_out", 32'(valid_out), 32'd0);
    cnts("post2", 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_cond_unit.md
BRANCH_COND_UNIT -- requirements
Module: branch_cond_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits.
REQ-002 Parameter PC_W, default 32: program-counter width in bits.
REQ-003 Parameter CNT_W, default 16: width of the statistics counters.
REQ-004 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1: asynchronous, active-low reset (0 = reset asserted).
REQ-006 Port valid_in  input  1: a branch request is present this cycle.
REQ-007 Port ready_in  output  1: the unit accepts a request this cycle.
REQ-008 Port op  input  3: condition select: 0 BEQ, 1 BNE, 2 BLEZ, 3 BGTZ, 4 BLTZ, 5 BGEZ, 6-7 reserved.
REQ-009 Port rs  input  WIDTH: first operand, signed two's complement.
REQ-010 Port rt  input  WIDTH: second operand, used by BEQ and BNE only.
REQ-011 Port pc  input  PC_W: address of the branch instruction.
REQ-012 Port imm  input  16: signed word offset.
REQ-013 Port valid_out  output  1: a registered result is present.
REQ-014 Port ready_out  input  1: the consumer accepts the result this cycle.
REQ-015 Port taken  output  1: the registered branch decision.
REQ-016 Port target  output  PC_W: the registered next-PC.
REQ-017 Port bad_op  output  1: the registered result came from a reserved op.
REQ-018 Port flush  output  1: pulses on the cycle a taken result transfers.
REQ-019 Port clear  input  1: synchronous clear of the statistics counters.
REQ-020 Port taken_cnt  output  CNT_W: count of transferred taken results.
REQ-021 Port total_cnt  output  CNT_W: count of all transferred results.

Function
REQ-022 Input transfer: occurs when valid_in=1 and ready_in=1.
REQ-023 Output transfer: occurs when valid_out=1 and ready_out=1.
REQ-024 ready_in SHALL equal (!valid_out | ready_out), combinationally.
REQ-025 Latency: a request accepted at edge N SHALL appear on valid_out and the result outputs after edge N.
- Latency is 1 cycle.
- Back-to-back throughput is 1 request per cycle while ready_out=1.
REQ-026 While valid_out=1 and ready_out=0, taken, target and bad_op SHALL hold stable.
REQ-027 valid_out SHALL clear after an output transfer with no simultaneous input transfer.
REQ-028 valid_out SHALL stay 1 when an output transfer and an input transfer coincide; the new result replaces the old.
REQ-029 Conditions, signed over WIDTH bits:
- BEQ: rs==rt.
- BNE: rs!=rt.
- BLEZ: rs<=0.
- BGTZ: rs>0.
- BLTZ: rs<0.
- BGEZ: rs>=0.
REQ-030 Reserved op (6 or 7): taken=0 and bad_op=1; otherwise bad_op=0.
REQ-031 Taken target: pc + 4 + (sign-extended imm shifted left by 2), computed modulo 2^PC_W; wrap-around is silent.
REQ-032 Not-taken target: pc + 4 modulo 2^PC_W.
REQ-033 flush SHALL equal (valid_out & ready_out & taken), combinationally.
REQ-034 On each output transfer, total_cnt SHALL increment by 1, and taken_cnt SHALL increment by 1 if taken=1.
REQ-035 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-036 When clear=1, both counters SHALL be 0 after the edge; clear overrides any coincident increment.
REQ-037 Inputs sampled while valid_in=0 or ready_in=0 SHALL have no effect on state.

Reset
REQ-038 When reset=0, the following SHALL take effect immediately, without waiting for clk:
- valid_out=0, taken=0, target=0, bad_op=0.
- taken_cnt=0, total_cnt=0.
REQ-039 While reset=0, ready_in SHALL be 1 and flush SHALL be 0.
REQ-040 A result pending when reset asserts SHALL be discarded and never transferred or counted.
REQ-041 The first input transfer SHALL be possible on the first rising edge after reset returns to 1.

Verification
REQ-042 BEQ, rs=rt=0x00000005, pc=0x00400000, imm=0x0003, ready_out=1:
- One cycle later: valid_out=1, taken=1, target=0x00400010, flush=1.
- taken_cnt=1, total_cnt=1.
REQ-043 BLEZ/BGTZ, rs=0x80000000, pc=0x00400100, imm=0xFFFF:
- BLEZ: taken=1, target=0x00400100.
- BGTZ: taken=0, target=0x00400104.
REQ-044 Backpressure: ready_out=0 for 3 cycles after a result appears, with valid_in held at 1:
- Result holds stable and ready_in=0.
- Raising ready_out gives one transfer per cycle thereafter, with no loss or duplication.
REQ-045 op=7, pc=0xFFFFFFFC:
- taken=0, bad_op=1, target=0x00000000 (wrap), flush=0.
- total_cnt increments and taken_cnt does not.
REQ-046 CNT_W=4, 20 taken transfers:
- taken_cnt=total_cnt=15 (saturated).
- Asserting clear in the same cycle as a transfer gives 0.
REQ-047 Reset asserted between clock edges while valid_out=1 and ready_out=0:
- valid_out=0 and both counters=0 before the next edge.
- The pending result never appears after reset releases.
